// File: rtl/rps_pkg.sv
// Shared types and helpers for the three-player rock-paper-scissors referee.
// Hand encodings, FSM states, winner constants and the "who beats whom" rule.
package rps_pkg;

  typedef enum logic [1:0] {
    HAND_NONE     = 2'b00,
    HAND_ROCK     = 2'b01,
    HAND_SCISSORS = 2'b10,
    HAND_PAPER    = 2'b11
  } hand_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_WAIT_HANDS = 2'b01,
    ST_JUDGE      = 2'b10,
    ST_DONE       = 2'b11
  } state_t;

  localparam logic [2:0] WIN_NONE = 3'b000;
  localparam logic [2:0] WIN_DRAW = 3'b111;

  // True when h1 beats h2 (rock>scissors, scissors>paper, paper>rock).
  function automatic logic beats(input logic [1:0] h1, input logic [1:0] h2);
    logic res;
    case ({h1, h2})
      4'b0110: res = 1'b1;
      4'b1011: res = 1'b1;
      4'b1101: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic is_single(input logic [2:0] m);
    return (m != 3'b000) && ((m & (m - 3'b001)) == 3'b000);
  endfunction

endpackage

// File: rtl/rps_referee_if.sv
// Hand-submission handshake between the player front end and the referee.
interface rps_referee_if;
  logic [1:0] A_HAND;
  logic [1:0] B_HAND;
  logic [1:0] C_HAND;
  logic       HAND_VALID;
  logic       HAND_READY;

  modport master (output A_HAND, output B_HAND, output C_HAND, output HAND_VALID,
                  input  HAND_READY);
  modport slave  (input  A_HAND, input  B_HAND, input  C_HAND, input  HAND_VALID,
                  output HAND_READY);
endinterface

// File: rtl/rps_judge.sv
// Combinational round judge: given the captured hands and the active mask,
// produce the mask of players that survive the round. Mask bit 2 = A, 0 = C.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] a_hand_i,
  input  logic [1:0] b_hand_i,
  input  logic [1:0] c_hand_i,
  input  logic [2:0] mask_i,
  output logic [2:0] mask_o
);

  logic [1:0] hand_s [3];
  logic [2:0] valid_m_s;
  logic [2:0] beaten_s;
  logic       has_rock_s;
  logic       has_sci_s;
  logic       has_pap_s;
  logic [1:0] distinct_s;

  // Forfeit filter, distinct-hand census and per-player "beaten" flags.
  always_comb begin
    hand_s[2] = a_hand_i;
    hand_s[1] = b_hand_i;
    hand_s[0] = c_hand_i;
    for (int i = 0; i < 3; i++) begin
      valid_m_s[i] = mask_i[i] & (hand_s[i] != HAND_NONE);
    end
    has_rock_s = 1'b0;
    has_sci_s  = 1'b0;
    has_pap_s  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      has_rock_s = has_rock_s | (valid_m_s[i] & (hand_s[i] == HAND_ROCK));
      has_sci_s  = has_sci_s  | (valid_m_s[i] & (hand_s[i] == HAND_SCISSORS));
      has_pap_s  = has_pap_s  | (valid_m_s[i] & (hand_s[i] == HAND_PAPER));
    end
    distinct_s = {1'b0, has_rock_s} + {1'b0, has_sci_s} + {1'b0, has_pap_s};
    for (int i = 0; i < 3; i++) begin
      beaten_s[i] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        beaten_s[i] = beaten_s[i] | (valid_m_s[j] & beats(hand_s[j], hand_s[i]));
      end
    end
  end

  // All-forfeit keeps the mask; with two distinct hands the beaten side drops out.
  always_comb begin
    mask_o = mask_i;
    if (valid_m_s == 3'b000) begin
      mask_o = mask_i;
    end else if (distinct_s == 2'd2) begin
      mask_o = valid_m_s & ~beaten_s;
    end else begin
      mask_o = valid_m_s;
    end
  end

endmodule

// File: rtl/rps_referee.sv
// Three-player rock-paper-scissors game controller: collects hands, judges
// rounds via rps_judge, and presents survivors and the final winner mask.
module rps_referee
  import rps_pkg::*;
#(
  parameter int MAX_ROUNDS = 8,
  parameter int RW         = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  rps_referee_if.slave  hs,
  output logic [2:0]    Winner_DISP,
  output logic          A_DISP,
  output logic          B_DISP,
  output logic          C_DISP,
  output logic [RW-1:0] ROUND,
  output logic          DONE
);

  localparam logic [RW-1:0] ROUND_ONE = RW'(1);
  localparam logic [RW-1:0] ROUND_MAX = RW'(MAX_ROUNDS);

  state_t        state_q, state_d;
  logic [2:0]    mask_q, mask_d;
  logic [RW-1:0] round_q, round_d;
  logic [2:0]    win_q, win_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic [1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]    judged_s;
  logic [RW-1:0] round_inc_s;

  rps_judge u_judge (
    .a_hand_i (a_q),
    .b_hand_i (b_q),
    .c_hand_i (c_q),
    .mask_i   (mask_q),
    .mask_o   (judged_s)
  );

  assign round_inc_s = round_q + ROUND_ONE;

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    round_d = round_q;
    win_d   = win_q;
    done_d  = done_q;
    ready_d = ready_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_WAIT_HANDS;
          mask_d  = 3'b111;
          round_d = '0;
          win_d   = WIN_NONE;
          done_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_HANDS: begin
        if (hs.HAND_VALID && ready_q) begin
          a_d     = hs.A_HAND;
          b_d     = hs.B_HAND;
          c_d     = hs.C_HAND;
          ready_d = 1'b0;
          state_d = ST_JUDGE;
        end else begin
          state_d = ST_WAIT_HANDS;
        end
      end
      ST_JUDGE: begin
        mask_d  = judged_s;
        round_d = round_inc_s;
        if (is_single(judged_s) || (round_inc_s == ROUND_MAX)) begin
          win_d   = judged_s;
          done_d  = 1'b1;
          ready_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          ready_d = 1'b1;
          state_d = ST_WAIT_HANDS;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      mask_q  <= 3'b111;
      round_q <= '0;
      win_q   <= WIN_NONE;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      a_q     <= HAND_NONE;
      b_q     <= HAND_NONE;
      c_q     <= HAND_NONE;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      round_q <= round_d;
      win_q   <= win_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign hs.HAND_READY = ready_q;
  assign Winner_DISP   = win_q;
  assign A_DISP        = mask_q[2];
  assign B_DISP        = mask_q[1];
  assign C_DISP        = mask_q[0];
  assign ROUND         = round_q;
  assign DONE          = done_q;

endmodule

// File: doc/rps_referee.md
Name: rps_referee

Overview:
- Game-control block for the three-player rock-paper-scissors design. It produces the winner code and per-player status that the existing display block consumes each clock.
- Accepts one hand per player per round through a valid/ready handshake and judges each round. Losers and invalid-hand players are eliminated.
- The game ends with a single survivor, or with the survivors at the round limit. The final result is presented on Winner_DISP.

Parameters:
- MAX_ROUNDS, 8, rounds after which the game ends with the current survivors as joint winners; legal range 1..(2^RW-1)
- RW, 4, width of the ROUND counter

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  synchronous, active-low reset
- START  in  1  begin a new game; sampled only in IDLE and DONE
- A_HAND  in  2  player A hand: 00 none/invalid, 01 rock, 10 scissors, 11 paper
- B_HAND  in  2  player B hand, same encoding
- C_HAND  in  2  player C hand, same encoding
- HAND_VALID  in  1  all three hands present this cycle
- HAND_READY  out  1  referee accepts hands this cycle
- Winner_DISP  out  3  {A,B,C} winner mask; 000 while no result, 111 = draw (all three survive)
- A_DISP  out  1  player A still in game
- B_DISP  out  1  player B still in game
- C_DISP  out  1  player C still in game
- ROUND  out  RW  completed rounds in the current game
- DONE  out  1  result valid; held until the next START

Behaviour:
- Reset (RST=0 at a rising edge):
  - state=IDLE, Winner_DISP=000, A/B/C_DISP=1, ROUND=0, HAND_READY=0, DONE=0.
  - Reset mid-game abandons the game, including during JUDGE; no partial update survives.
- States: IDLE, WAIT_HANDS, JUDGE, DONE.
- IDLE:
  - START=1 -> WAIT_HANDS; active mask=111, ROUND=0, Winner_DISP=000.
- WAIT_HANDS:
  - HAND_READY=1 (registered, asserted from the first cycle in this state).
  - HAND_VALID && HAND_READY at an edge: capture all three hands, -> JUDGE, HAND_READY drops.
  - START ignored.
- JUDGE (exactly one cycle, HAND_READY=0). Evaluated by rps_judge on the captured hands and current mask:
  1. An active player with hand 00 is eliminated, unless every active player has 00; then there are no eliminations and the round is a tie.
  2. Among the remaining active valid hands, take the set of distinct hands:
     - size 1 or 3 -> tie, no change;
     - size 2 -> the beating hand wins (rock>scissors, scissors>paper, paper>rock); holders of the losing hand are eliminated.
  3. Inactive players' hands are ignored entirely.
  4. The mask can never become 000.
- End of the JUDGE cycle, at the next edge:
  - new mask -> A/B/C_DISP; ROUND <= ROUND+1.
  - If popcount(new mask)==1 or ROUND+1==MAX_ROUNDS: Winner_DISP <= new mask, DONE <= 1, -> DONE.
  - Otherwise -> WAIT_HANDS with Winner_DISP still 000.
- Latency: hands accepted at edge t; mask/ROUND/Winner updated at edge t+1; HAND_READY high again from edge t+1 when play continues.
- DONE state:
  - Outputs held stable.
  - START=1 behaves as START from IDLE: same-edge restart, DONE <= 0, Winner_DISP <= 000, mask <= 111, ROUND <= 0.
- Invariants:
  - Winner_DISP==000 exactly when DONE==0.
  - In DONE, Winner_DISP equals {A_DISP,B_DISP,C_DISP}.
  - ROUND never exceeds MAX_ROUNDS and never wraps.
- HAND_VALID outside WAIT_HANDS is ignored; hands are not buffered.

Decomposition:
- Package rps_pkg:
  - hand encodings HAND_NONE/ROCK/SCISSORS/PAPER;
  - state enum;
  - constants WIN_NONE=3'b000, WIN_DRAW=3'b111;
  - function beats(h1,h2).
- Sub-module rps_judge: purely combinational; inputs three hands + active mask, output next mask. Instantiated once.

Test Plan:
- Elimination win: RST=0 then 1, START; hands A=01,B=10,C=10 -> next edge Winner_DISP=100, A/B/C_DISP=1/0/0, ROUND=1, DONE=1, HAND_READY=0.
- Tie then win: START; A=01,B=11,C=10 (all distinct) -> mask 111, Winner 000, ROUND=1, HAND_READY=1. Then A=01,B=01,C=11 -> Winner 001, ROUND=2.
- Two-stage with ignored hand: round 1 A=01,B=01,C=10 -> mask 110, Winner 000. Round 2 A=11,B=01,C=00 -> Winner 100, ROUND=2.
- Invalid forfeit: A=00,B=01,C=01 -> mask 011, Winner 000. All-invalid A=B=C=00 -> no change, ROUND increments.
- Round limit: MAX_ROUNDS=8, eight all-distinct rounds -> after 8th judge Winner_DISP=111, DONE=1, ROUND=8. START in DONE -> Winner 000, ROUND 0, DONE 0 next edge.
- Reset mid-game: hold HAND_VALID, assert RST=0 on the JUDGE cycle -> next edge IDLE values (Winner 000, DISP 111, ROUND 0, HAND_READY 0). HAND_VALID without START -> no effect.
